// File: rtl/button_event.sv
// button_event: turns a debounced button level into press/release/click/long/repeat pulses.
module button_event #(
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int REPEAT_EN     = 1,
  parameter int CNT_W         = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal_i,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic long_p,
  output logic repeat_p,
  output logic held_o
);
  typedef enum logic [1:0] {WAIT_LOW, IDLE, PRESSED, HELD} state_t;
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = CNT_W'(REPEAT_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic press_d, release_d, click_d, long_d, repeat_d, held_d;
  logic at_long, at_rep;
  assign at_long = cnt_q == LONG_M1;
  assign at_rep  = (REPEAT_EN != 0) && (cnt_q == REP_M1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
      held_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_p   <= press_d;
      release_p <= release_d;
      click_p   <= click_d;
      long_p    <= long_d;
      repeat_p  <= repeat_d;
      held_o    <= held_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOW: state_d = signal_i ? WAIT_LOW : IDLE;
      IDLE: if (signal_i) begin
        state_d = PRESSED;
        cnt_d   = CNT_W'(1);
      end
      PRESSED: begin
        state_d = !signal_i ? IDLE : at_long ? HELD : PRESSED;
        cnt_d   = (!signal_i || at_long) ? '0 : cnt_q + 1'b1;
      end
      HELD: begin
        state_d = signal_i ? HELD : IDLE;
        // Repeat disabled pins the counter at 0; otherwise it reloads at each pulse.
        cnt_d   = (!signal_i || REPEAT_EN == 0 || at_rep) ? '0 : cnt_q + 1'b1;
      end
    endcase
  end
  always_comb begin
    press_d   = state_q == IDLE && signal_i;
    release_d = (state_q == PRESSED || state_q == HELD) && !signal_i;
    click_d   = state_q == PRESSED && !signal_i;
    long_d    = state_q == PRESSED && signal_i && at_long;
    repeat_d  = state_q == HELD && signal_i && at_rep;
    held_d    = state_d == PRESSED || state_d == HELD;
  end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: directed scenarios with a scoreboard of expected output vectors.
module tb_button_event;
  localparam int L = 8;
  localparam int R = 4;
  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    string      tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signal_i = 1'b0;
  logic pa, ra, ca, la, ta, ha;
  logic pb, rb, cb, lb, tb, hb;
  logic [5:0] va, vb;
  exp_t sb[$];
  int vectors = 0;
  int errs = 0;
  assign va = {pa, ra, ca, la, ta, ha};
  assign vb = {pb, rb, cb, lb, tb, hb};
  always #5 clk = ~clk;
  button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .signal_i(signal_i),
    .press_p(pa), .release_p(ra), .click_p(ca), .long_p(la), .repeat_p(ta), .held_o(ha)
  );
  button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_EN(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .signal_i(signal_i),
    .press_p(pb), .release_p(rb), .click_p(cb), .long_p(lb), .repeat_p(tb), .held_o(hb)
  );
  // Vector order: {press, release, click, long, repeat, held}; k counts edges after E0.
  function automatic logic [5:0] hi(input int k, input bit ren);
    return {k == 0, 2'b00, k == L - 1, ren && k >= L - 1 + R && (k - (L - 1)) % R == 0, 1'b1};
  endfunction
  function automatic logic [5:0] lo(input int n);
    return {1'b0, 1'b1, n < L, 3'b000};
  endfunction
  task automatic check();
    exp_t e;
    e = sb.pop_front();
    vectors += 2;
    assert (va === e.a) else begin
      errs++;
      $error("FAIL %s dut_a got %b exp %b", e.tag, va, e.a);
    end
    assert (vb === e.b) else begin
      errs++;
      $error("FAIL %s dut_b got %b exp %b", e.tag, vb, e.b);
    end
  endtask
  task automatic now(input string tag);
    sb.push_back('{6'b0, 6'b0, tag});
    check();
  endtask
  task automatic step(input logic s, input logic [5:0] ea, input logic [5:0] eb, input string tag);
    signal_i = s;
    sb.push_back('{ea, eb, tag});
    @(posedge clk);
    #1;
    check();
  endtask
  task automatic hold(input int n, input bit rel, input string tag);
    for (int k = 0; k < n; k++) step(1'b1, hi(k, 1'b1), hi(k, 1'b0), tag);
    if (rel) step(1'b0, lo(n), lo(n), tag);
  endtask
  initial begin
    signal_i = 1'b1;
    #3;
    now("reset");
    step(1'b1, 6'b0, 6'b0, "in_reset");
    step(1'b1, 6'b0, 6'b0, "in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 6'b0, 6'b0, "wait_low");
    step(1'b0, 6'b0, 6'b0, "wait_low_exit");
    hold(3, 1'b1, "short3");
    step(1'b0, 6'b0, 6'b0, "idle");
    hold(7, 1'b1, "click7");
    hold(8, 1'b1, "long8");
    step(1'b0, 6'b0, 6'b0, "idle");
    hold(20, 1'b1, "repeat20");
    hold(2, 1'b1, "repress_a");
    hold(1, 1'b1, "repress_b");
    step(1'b0, 6'b0, 6'b0, "idle");
    hold(11, 1'b0, "rst_hold");
    #2;
    rst_n = 1'b0;
    #1;
    now("async_rst");
    step(1'b1, 6'b0, 6'b0, "in_reset2");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 6'b0, 6'b0, "post_rst_high");
    step(1'b0, 6'b0, 6'b0, "post_rst_low");
    hold(4, 1'b1, "after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 50000000, consecutive high samples (including the first) that qualify a long press; legal range >= 2.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10000000, cycles between auto-repeat pulses after a long press; legal range >= 1.
REQ-003 SHALL have parameter REPEAT_EN, default 1, meaning 1 enables auto-repeat and 0 suppresses it.
REQ-004 SHALL have parameter CNT_W, default 27, counter width; it must hold max(LONG_CYCLES, REPEAT_CYCLES).
REQ-005 SHALL have port clk  input  1  single system clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port signal_i  input  1  debounced, clk-synchronous button level, high = pressed.
REQ-008 SHALL have port press_p  output  1  one-cycle pulse on an accepted press.
REQ-009 SHALL have port release_p  output  1  one-cycle pulse on any release of an accepted press.
REQ-010 SHALL have port click_p  output  1  one-cycle pulse on release before the long threshold.
REQ-011 SHALL have port long_p  output  1  one-cycle pulse when the long threshold is reached.
REQ-012 SHALL have port repeat_p  output  1  one-cycle auto-repeat pulse.
REQ-013 SHALL have port held_o  output  1  level, high while an accepted press is in progress.

Function
REQ-014 SHALL register every output; the block has no combinational path from signal_i to any output.
REQ-015 SHALL implement states WAIT_LOW, IDLE, PRESSED and HELD.
REQ-016 SHALL go from WAIT_LOW to IDLE on the first edge where signal_i samples 0; it stays in WAIT_LOW while signal_i is 1, and emits no events there.
REQ-017 SHALL, in IDLE, go to PRESSED on an edge E0 where signal_i samples 1; it then drives press_p=1 for the following cycle, sets held_o=1 and loads the counter with 1.
REQ-018 SHALL, in PRESSED, increment the counter on each edge where signal_i samples 1.
REQ-019 SHALL, in PRESSED, when the counter equals LONG_CYCLES-1 and signal_i samples 1 at edge E0+LONG_CYCLES-1, go to HELD, pulse long_p and clear the counter.
REQ-020 SHALL, in PRESSED, on an edge sampling signal_i=0, pulse click_p and release_p in the same cycle, clear held_o and return to IDLE.
REQ-021 SHALL, in HELD with REPEAT_EN=1, increment the counter each edge and pulse repeat_p at edges E0+LONG_CYCLES-1+n*REPEAT_CYCLES (n>=1), reloading the counter to 0 at each pulse; the counter never wraps.
REQ-022 SHALL, in HELD with REPEAT_EN=0, never assert repeat_p and hold the counter at 0.
REQ-023 SHALL, in HELD, on an edge sampling signal_i=0, pulse release_p only (no click_p, no repeat_p), clear held_o and return to IDLE.
REQ-024 SHALL give release priority over repeat when a repeat edge coincides with signal_i=0.
REQ-025 SHALL allow a release followed by a re-press on the next edge, producing press_p in the cycle after release_p with no extra idle cycle.
REQ-026 SHALL keep press_p, release_p, click_p, long_p and repeat_p mutually exclusive, except that click_p and release_p coincide.

Reset
REQ-027 SHALL, while rst_n=0, immediately and asynchronously drive all outputs to 0, the counter to 0 and the state to WAIT_LOW.
REQ-028 SHALL, when reset is asserted mid-press, abandon that press and emit no release_p or click_p for it.
REQ-029 SHALL, after rst_n deasserts with signal_i high, generate no press until signal_i has sampled low at least once.

Verification
REQ-030 SHALL run all directed scenarios with LONG_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1 unless stated.
REQ-031 SHALL cover: reset released with signal_i=1 for 5 cycles, then 0, then 1 -> no pulse during the first high interval; exactly one press_p after the re-press.
REQ-032 SHALL cover: signal_i high for 3 samples then low -> press_p once; click_p and release_p together 3 cycles later; long_p and repeat_p never assert.
REQ-033 SHALL cover: signal_i high for exactly 7 samples then low -> click_p and release_p with no long_p; high for exactly 8 samples -> long_p after edge E0+7 and release_p without click_p.
REQ-034 SHALL cover: signal_i high for 20 samples (edges E0..E0+19) then low -> long_p after E0+7, repeat_p after E0+11, E0+15 and E0+19 (three total), release_p after E0+20; the same stimulus with REPEAT_EN=0 gives zero repeat_p.
REQ-035 SHALL cover: rst_n pulsed low at E0+10 during a hold -> all outputs 0 in the same cycle; no release_p; signal_i kept high after deassert gives no events until a low sample.
REQ-036 SHALL cover: signal_i pattern 1,1,0,1 -> press_p, release_p with click_p, press_p on consecutive-edge timing per REQ-025; held_o drops for exactly one cycle.
